// File: rtl/prog_loader_pkg.sv
// prog_loader shared types: opcode classes, halt word, FSM states.
// Imported by prog_loader and anything that decodes its words.
package prog_loader_pkg;

  localparam logic [2:0] OP_MEM  = 3'b000;
  localparam logic [2:0] OP_IMM  = 3'b001;
  localparam logic [2:0] OP_BR   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [8:0] HALT_WORD = 9'b111_000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: encodes {op,operand} requests into 9-bit words, writes
// them from address 0 upward, appends a halt word, reports Length.
// Ports: Clk, Reset_n (sync, low), Start, InValid/InReady/InOp/
// InOperand/InLast request side, MemWe/MemAddr/MemWData write side,
// Done, Error, Length status.
// Optional: `define PROG_LOADER_CHECKSUM_EN adds Checksum (9b XOR
// of all words written since Start, halt included).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              InValid,
  output logic              InReady,
  input  logic [2:0]        InOp,
  input  logic [5:0]        InOperand,
  input  logic              InLast,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [8:0]        MemWData,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W:0]   Length
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic [8:0]        Checksum
`endif
);

  // Counter is one bit wider than the address so it can hold DEPTH
  // once the halt lands in the final slot.
  localparam logic [ADDR_W:0] FULL_CNT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [ADDR_W:0]   cnt, cnt_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [8:0]        wd_n;
  logic              done_n, err_n;
  logic [ADDR_W:0]   len_n;
  logic              full, accept, rsvd;
  logic [8:0]        word;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [8:0]        chk_n;
`endif

  assign full    = (cnt == FULL_CNT);
  assign InReady = (state == S_LOAD) && !full;
  assign accept  = InValid && InReady && !Start;
  assign word    = {InOp, InOperand};
  assign rsvd    = (InOp == OP_HALT) && (InOperand != 6'd0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we_n    = 1'b0;
    addr_n  = MemAddr;
    wd_n    = MemWData;
    if (Start) begin
      state_n = S_LOAD;
      cnt_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_LOAD: begin
          if (InValid && full) begin
            state_n = S_ERR;
          end else if (accept) begin
            if (rsvd) begin
              state_n = S_ERR;
            end else begin
              we_n   = 1'b1;
              addr_n = cnt[ADDR_W-1:0];
              wd_n   = word;
              cnt_n  = cnt + ONE;
              if (InLast || InOp == OP_HALT)
                state_n = S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          we_n    = 1'b1;
          addr_n  = cnt[ADDR_W-1:0];
          wd_n    = HALT_WORD;
          cnt_n   = cnt + ONE;
          state_n = S_DONE;
        end
        S_DONE: ;
        S_ERR: ;
        default: state_n = S_IDLE;
      endcase
    end
    // Status is registered off the current state, so it trails the
    // state by one cycle and drops the cycle after a Start.
    done_n = (state == S_DONE) && !Start;
    err_n  = (state == S_ERR) && !Start;
    len_n  = (done_n || err_n) ? cnt : '0;
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_comb begin
    chk_n = Checksum;
    if (Start)
      chk_n = '0;
    else if (we_n)
      chk_n = Checksum ^ wd_n;
  end
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      Done     <= 1'b0;
      Error    <= 1'b0;
      Length   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      Checksum <= '0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      MemWe    <= we_n;
      MemAddr  <= addr_n;
      MemWData <= wd_n;
      Done     <= done_n;
      Error    <= err_n;
      Length   <= len_n;
`ifdef PROG_LOADER_CHECKSUM_EN
      Checksum <= chk_n;
`endif
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Sequential program loader that writes the 9-bit instruction store read by the fetch/control path. It accepts a stream of field-level instruction requests over a valid/ready handshake, encodes each into a 9-bit machine word using the core opcode map, and writes the words to consecutive instruction-memory addresses. After the last request it appends a terminating halt word, then reports the program length. The block sits between the host/test harness and the instruction memory's write port.

## Interface
- `ADDR_W`, 10: instruction memory address width; depth = 2**ADDR_W words.
- `Clk`  in  1  single clock, all state updates on rising edge.
- `Reset_n`  in  1  reset, synchronous and active-low.
- `Start`  in  1  one-cycle pulse; (re)starts a program load at address 0.
- `InValid`  in  1  request valid.
- `InReady`  out  1  request accepted when `InValid && InReady`.
- `InOp`  in  3  opcode class (000 mem, 001 immediate ALU, 010–101 ALU, 110 branch, 111 halt).
- `InOperand`  in  6  operand field, becomes word[5:0].
- `InLast`  in  1  marks final request of the program.
- `MemWe`  out  1  instruction-memory write strobe.
- `MemAddr`  out  ADDR_W  write address.
- `MemWData`  out  9  encoded word {InOp, InOperand}.
- `Done`  out  1  high while in DONE.
- `Error`  out  1  high while in ERR.
- `Length`  out  ADDR_W+1  words written, including appended halt.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DONE, ERR. Reset → IDLE.
- IDLE: `InReady`=0. `Start` → LOAD, word counter cleared to 0.
- LOAD: `InReady`=1 unless counter == DEPTH-1 (last slot reserved for halt).
  - Accept → register word {InOp, InOperand} at address = counter; counter+1.
  - Accepted `InOp`==111 with `InOperand`!=0 → ERR (reserved encoding), nothing written.
  - Accepted `InOp`==111 with operand 0 → written; treated as `InLast`.
  - Accepted `InLast` → FLUSH after the write.
  - `InValid` while counter == DEPTH-1 (full) → ERR.
- FLUSH: write 9'b111_000000 at address = counter; counter+1; → DONE.
- DONE: `Done`=1, `Length`=counter. Held until `Start`.
- ERR: `Error`=1, `Length`=counter (words written before fault). Held until `Start`.
- `Start` in any state, including mid-LOAD: → LOAD, counter 0, pending write still issued (it belongs to the aborted load); `Done`/`Error` clear next cycle.
- `Start` and `InValid` same cycle: `Start` wins, request not accepted.
- Counter never wraps; full check prevents it.

## Timing
- Reset values: `InReady`=0, `MemWe`=0, `MemAddr`=0, `MemWData`=0, `Done`=0, `Error`=0, `Length`=0.
- Write latency: request accepted in cycle N → `MemWe`=1 with address/data in cycle N+1 (registered outputs).
- Back-to-back: one request per cycle sustained in LOAD.
- `InReady` is a registered/state function; it does not depend combinationally on `InValid`.
- Last request accepted in N → its write N+1, halt write N+2, `Done`=1 from N+3.
- `MemWe` is a single-cycle pulse per word; low in IDLE, DONE, ERR.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined: adds output `Checksum` (9 bits), XOR of every word written since `Start`, including halt; reset and `Start` clear it to 0; valid while `Done`=1.
- Undefined: port and logic absent; all other behaviour identical.

## Structure
- Shared package: opcode class constants (OP_MEM, OP_IMM, OP_BR, OP_HALT), HALT_WORD = 9'b111_000000, FSM state enum.
- Single module; no sub-module required (encoder is a concatenation plus reserved-encoding check inline).

## Test plan
- Start, then three requests (000/000011, 010/000101, 110/111111, last on third) → writes 0x003@0, 0x085@1, 0x1BF@2, 0x1C0@3; `Done`=1, `Length`=4.
- Request with `InOp`=111, `InOperand`=000001 → no write, `Error`=1, `Length`=words before it.
- `ADDR_W`=2: send 4 requests without `InLast` → first 3 written, `InReady`=0 at counter 3, fourth `InValid` → ERR, `Length`=3.
- `Start` asserted after 2 accepted requests → loading restarts at address 0; next request written at 0; final `Length` counts only new words plus halt.
- `Reset_n`=0 mid-LOAD for one cycle → all outputs reset values next cycle, state IDLE, no further `MemWe`.
- With `PROG_LOADER_CHECKSUM_EN`: words 0x003, 0x085 (last) → `Checksum` = 0x003^0x085^0x1C0 = 0x146 when `Done`=1.
